// File: rtl/ip_param_buf_writer_pkg.sv
// Shared types and default sizing for the FC-layer parameter buffer writer.
// Word width, set length and beat width defaults match the FP32 build.
package ip_param_buf_writer_pkg;

    localparam int DEF_FW         = 32;
    localparam int DEF_WL         = 288;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_AW         = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BUF = 2'd1,
        ST_FILL     = 2'd2,
        ST_DONE     = 2'd3
    } wr_state_t;

endpackage

// File: rtl/ip_param_buf_writer_unpack.sv
// Holds one DDR beat and presents its words one at a time, lowest word first.
// The hold empties after the last word, on an early discard at set end, or on flush.
module ip_beat_unpack
    import ip_param_buf_writer_pkg::*;
#(
    parameter int FW  = DEF_FW,
    parameter int WPB = DEF_DATA_WIDTH / DEF_FW
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              i_load,
    input  logic [FW*WPB-1:0] i_beat,
    input  logic              i_advance,
    input  logic              i_discard,
    input  logic              i_flush,
    output logic              o_hold_valid,
    output logic [FW-1:0]     o_word
);

    localparam int IDXW = (WPB > 1) ? $clog2(WPB) : 1;

    logic [FW*WPB-1:0] r_hold;
    logic              r_hold_valid;
    logic [IDXW-1:0]   r_word_idx;
    logic [FW-1:0]     w_words [WPB];
    logic              w_last_word;

    generate
        for (genvar gi = 0; gi < WPB; gi++) begin : g_word
            assign w_words[gi] = r_hold[gi*FW +: FW];
        end
    endgenerate

    assign w_last_word  = (r_word_idx == IDXW'(WPB - 1));
    assign o_word       = w_words[r_word_idx];
    assign o_hold_valid = r_hold_valid;

    // Load and advance never coincide: a beat is only accepted while the hold is empty.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_word_idx   <= '0;
        end else if (i_flush || i_discard || (i_advance && w_last_word)) begin
            r_hold_valid <= 1'b0;
            r_word_idx   <= '0;
        end else if (i_load) begin
            r_hold       <= i_beat;
            r_hold_valid <= 1'b1;
            r_word_idx   <= '0;
        end else if (i_advance) begin
            r_word_idx   <= r_word_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/ip_param_buf_writer.sv
// Write side of the ping-pong parameter buffer: unpacks DDR beats into one neuron's
// weight+bias set and writes it into the half the reader currently offers.
module ip_param_buf_writer
    import ip_param_buf_writer_pkg::*;
#(
    parameter int FW         = DEF_FW,
    parameter int WL         = DEF_WL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AW         = DEF_AW
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] ddr_data_i,
    input  logic                  ddr_data_valid_i,
    output logic                  ddr_data_ready_o,
    input  logic                  wr_buf_sel_i,
    input  logic [1:0]            param_buf_full_i,
    input  logic                  ip_done_i,
    output logic                  wr_buf_en_o,
    output logic                  wr_buf_half_o,
    output logic [AW-1:0]         wr_buf_addr_o,
    output logic [FW-1:0]         wr_buf_data_o,
    output logic                  wr_buf_done_o
);

    localparam int             WPB       = DATA_WIDTH / FW;
    localparam int             BUF_WORDS = WL + 1;
    localparam logic [AW-1:0]  LAST_ADDR = AW'(BUF_WORDS - 1);

    wr_state_t     r_state;
    logic          r_last_pending;
    logic [AW-1:0] r_addr_cnt;
    logic          r_wr_en;
    logic          r_wr_half;
    logic [AW-1:0] r_wr_addr;
    logic [FW-1:0] r_wr_data;
    logic          r_wr_done;

    logic          w_hold_valid;
    logic [FW-1:0] w_word;
    logic          w_accept;
    logic          w_emit;
    logic          w_set_end;

    // Ready depends only on registered state, the hold and the flush request, never on valid.
    assign ddr_data_ready_o = (r_state == ST_FILL) && !w_hold_valid && !r_last_pending && !ip_done_i;
    assign w_accept         = ddr_data_valid_i && ddr_data_ready_o;
    assign w_emit           = (r_state == ST_FILL) && w_hold_valid && !r_last_pending;
    assign w_set_end        = w_emit && (r_addr_cnt == LAST_ADDR);

    ip_beat_unpack #(
        .FW  (FW),
        .WPB (WPB)
    ) u_unpack (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .i_load       (w_accept),
        .i_beat       (ddr_data_i),
        .i_advance    (w_emit),
        .i_discard    (w_set_end),
        .i_flush      (ip_done_i),
        .o_hold_valid (w_hold_valid),
        .o_word       (w_word)
    );

    // The done pulse is issued from FILL one cycle after the last write, so the reader's
    // sel/full update lands before WAIT_BUF samples them again.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state        <= ST_IDLE;
            r_last_pending <= 1'b0;
            r_addr_cnt     <= '0;
            r_wr_en        <= 1'b0;
            r_wr_half      <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_wr_done      <= 1'b0;
        end else if (ip_done_i) begin
            r_state        <= ST_IDLE;
            r_last_pending <= 1'b0;
            r_addr_cnt     <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_done      <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT_BUF;
                end
                ST_WAIT_BUF: begin
                    if (!param_buf_full_i[wr_buf_sel_i]) begin
                        r_wr_half  <= wr_buf_sel_i;
                        r_addr_cnt <= '0;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (r_last_pending) begin
                        r_last_pending <= 1'b0;
                        r_wr_done      <= 1'b1;
                        r_state        <= ST_DONE;
                    end else if (w_emit) begin
                        r_wr_en        <= 1'b1;
                        r_wr_addr      <= r_addr_cnt;
                        r_wr_data      <= w_word;
                        r_addr_cnt     <= r_addr_cnt + AW'(1);
                        r_last_pending <= w_set_end;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_WAIT_BUF;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_buf_en_o   = r_wr_en;
    assign wr_buf_half_o = r_wr_half;
    assign wr_buf_addr_o = r_wr_addr;
    assign wr_buf_data_o = r_wr_data;
    assign wr_buf_done_o = r_wr_done;

endmodule

// File: tb/tb_ip_param_buf_writer.sv
// Directed bench for the parameter buffer writer: full sets, half ping-pong,
// back-pressure, valid gaps, tail discard, flush and asynchronous reset mid-set.
module tb_ip_param_buf_writer;

    localparam int FW     = 32;
    localparam int DW     = 512;
    localparam int AW     = 9;
    localparam int WPB    = 16;
    localparam int BUFW   = 289;
    localparam int NBEATS = 19;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [DW-1:0] ddr_data_i;
    logic          ddr_data_valid_i;
    logic          ddr_data_ready_o;
    logic          wr_buf_sel_i;
    logic [1:0]    param_buf_full_i;
    logic          ip_done_i;
    logic          wr_buf_en_o;
    logic          wr_buf_half_o;
    logic [AW-1:0] wr_buf_addr_o;
    logic [FW-1:0] wr_buf_data_o;
    logic          wr_buf_done_o;

    always #5 clk_i = ~clk_i;

    ip_param_buf_writer dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .ddr_data_i       (ddr_data_i),
        .ddr_data_valid_i (ddr_data_valid_i),
        .ddr_data_ready_o (ddr_data_ready_o),
        .wr_buf_sel_i     (wr_buf_sel_i),
        .param_buf_full_i (param_buf_full_i),
        .ip_done_i        (ip_done_i),
        .wr_buf_en_o      (wr_buf_en_o),
        .wr_buf_half_o    (wr_buf_half_o),
        .wr_buf_addr_o    (wr_buf_addr_o),
        .wr_buf_data_o    (wr_buf_data_o),
        .wr_buf_done_o    (wr_buf_done_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          w_half_q[$];
    int          w_addr_q[$];
    logic [31:0] w_data_q[$];
    int          done_cnt;
    bit          done_follow_ok;
    bit          prev_en;
    int          prev_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: samples outputs on the falling edge and logs writes / done pulses.
    task automatic cycle();
        @(negedge clk_i);
        if (wr_buf_done_o === 1'b1) begin
            done_cnt++;
            if (!(prev_en && prev_addr == BUFW - 1)) done_follow_ok = 1'b0;
        end
        if (wr_buf_en_o === 1'b1) begin
            w_half_q.push_back(int'(wr_buf_half_o));
            w_addr_q.push_back(int'(wr_buf_addr_o));
            w_data_q.push_back(wr_buf_data_o);
            $display("write half=%0d addr=%0d data=%08h", wr_buf_half_o, wr_buf_addr_o, wr_buf_data_o);
        end
        prev_en   = (wr_buf_en_o === 1'b1);
        prev_addr = int'(wr_buf_addr_o);
    endtask

    task automatic clear_log();
        w_half_q.delete();
        w_addr_q.delete();
        w_data_q.delete();
        done_cnt       = 0;
        done_follow_ok = 1'b1;
    endtask

    function automatic logic [DW-1:0] mk_beat(input int tag, input int b);
        logic [DW-1:0] beat;
        logic [31:0]   w;
        int            idx;
        beat = '0;
        for (int k = 0; k < WPB; k++) begin
            idx = b * WPB + k;
            if (idx < BUFW) w = (32'(tag) << 16) | 32'(idx);
            else            w = 32'h0000_DEAD;
            beat[k*FW +: FW] = w;
        end
        return beat;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        int n;
        ddr_data_valid_i = 1'b0;
        repeat (gap) cycle();
        ddr_data_i       = d;
        ddr_data_valid_i = 1'b1;
        n = 0;
        #1;
        while (ddr_data_ready_o !== 1'b1 && n < 400) begin
            cycle();
            #1;
            n++;
        end
        chk("beat_accept", 64'(n < 400), 64'd1);
        cycle();
        ddr_data_valid_i = 1'b0;
    endtask

    task automatic send_set(input int tag, input int nbeats, input bit rnd_gaps);
        for (int b = 0; b < nbeats; b++)
            send_beat(mk_beat(tag, b), rnd_gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_done(input int max_cycles);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("done_seen", 64'(done_cnt), 64'(start + 1));
    endtask

    task automatic wait_addr(input int addr, input int max_cycles);
        int n;
        n = 0;
        while (!(prev_en && prev_addr == addr) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("reach_addr", 64'(prev_addr), 64'(addr));
    endtask

    task automatic check_set(input string nm, input int tag, input int half);
        int bad_addr;
        int bad_data;
        int bad_half;
        logic [31:0] exp_data;
        bad_addr = 0;
        bad_data = 0;
        bad_half = 0;
        for (int i = 0; i < w_addr_q.size(); i++) begin
            exp_data = (32'(tag) << 16) | 32'(i);
            if (w_addr_q[i] != i)        bad_addr++;
            if (w_data_q[i] !== exp_data) bad_data++;
            if (w_half_q[i] != half)     bad_half++;
        end
        chk({nm, "_count"},  64'(w_addr_q.size()), 64'(BUFW));
        chk({nm, "_addr"},   64'(bad_addr), 64'd0);
        chk({nm, "_data"},   64'(bad_data), 64'd0);
        chk({nm, "_half"},   64'(bad_half), 64'd0);
        chk({nm, "_ndone"},  64'(done_cnt), 64'd1);
        chk({nm, "_follow"}, 64'(done_follow_ok), 64'd1);
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_en"},    64'(wr_buf_en_o), 64'd0);
        chk({nm, "_done"},  64'(wr_buf_done_o), 64'd0);
        chk({nm, "_addr"},  64'(wr_buf_addr_o), 64'd0);
        chk({nm, "_data"},  64'(wr_buf_data_o), 64'd0);
        chk({nm, "_half"},  64'(wr_buf_half_o), 64'd0);
        chk({nm, "_ready"}, 64'(ddr_data_ready_o), 64'd0);
    endtask

    initial begin
        int bp_bad;
        rstn_i           = 1'b0;
        ddr_data_i       = '0;
        ddr_data_valid_i = 1'b0;
        wr_buf_sel_i     = 1'b0;
        param_buf_full_i = 2'b00;
        ip_done_i        = 1'b0;
        prev_en          = 1'b0;
        prev_addr        = 0;
        clear_log();

        // Reset state
        repeat (3) cycle();
        check_outputs_zero("reset");
        rstn_i = 1'b1;

        // Set 1 into half 0, back-to-back beats
        send_set(1, NBEATS, 1'b0);
        wait_done(60);
        wr_buf_sel_i     = 1'b1;
        param_buf_full_i = 2'b01;
        check_set("set1", 1, 0);
        clear_log();

        // Set 2 into half 1 after the reader flips
        send_set(2, NBEATS, 1'b0);
        wait_done(60);
        wr_buf_sel_i     = 1'b0;
        param_buf_full_i = 2'b11;
        check_set("set2", 2, 1);
        clear_log();

        // Both halves full: beats must be back-pressured
        ddr_data_i       = mk_beat(3, 0);
        ddr_data_valid_i = 1'b1;
        bp_bad = 0;
        repeat (10) begin
            cycle();
            #1;
            if (ddr_data_ready_o !== 1'b0) bp_bad++;
        end
        chk("bp_ready_high", 64'(bp_bad), 64'd0);
        chk("bp_writes", 64'(w_addr_q.size()), 64'd0);

        // Half 0 freed, set 3 with random valid gaps
        param_buf_full_i = 2'b10;
        send_set(3, NBEATS, 1'b1);
        wait_done(60);
        param_buf_full_i = 2'b00;
        check_set("set3", 3, 0);
        clear_log();

        // Flush at addr 100
        send_set(4, 7, 1'b0);
        wait_addr(100, 100);
        ip_done_i = 1'b1;
        cycle();
        ip_done_i = 1'b0;
        chk("abort_en_stop", 64'(wr_buf_en_o), 64'd0);
        repeat (20) cycle();
        chk("abort_count", 64'(w_addr_q.size()), 64'd101);
        chk("abort_last_addr", 64'(w_addr_q[w_addr_q.size()-1]), 64'd100);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        clear_log();

        // Fresh set after flush restarts at addr 0
        send_set(5, NBEATS, 1'b0);
        wait_done(60);
        check_set("set5", 5, 0);
        clear_log();

        // Asynchronous reset at addr 200
        send_set(6, 13, 1'b0);
        wait_addr(200, 100);
        rstn_i = 1'b0;
        #1;
        check_outputs_zero("arst");
        cycle();
        rstn_i = 1'b1;
        repeat (5) cycle();
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        clear_log();

        // Full set after reset release
        send_set(7, NBEATS, 1'b1);
        wait_done(60);
        check_set("set7", 7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
